rx_74hc595: RTL and testbench

Synthesizable receiving end of the 74HC595 serial link. It oversamples the SHCP, STCP, DS and OE pins with the system clock and reconstructs the parallel word the shift-register driver sent. It presents that word with a valid strobe and a frame-length check. It sits on the far side of the link, either in loopback on the FPGA or as a bench-side checker, and decodes the 12-bit {segments, anodes} frames produced by the display path.

---
 rtl/rx_74hc595.sv | 116 +++++++++++
 tb/tb_rx_74hc595.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_74hc595.sv
// rx_74hc595 -- receiving end of a 74HC595 serial link; rebuilds each latched frame from SHCP/STCP/DS.
// Rev 1.0
`default_nettype none

module rx_74hc595 #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CNTW        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_shcp,
  input  logic             i_stcp,
  input  logic             i_ds,
  input  logic             i_oe,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_err,
  output logic [CNTW-1:0]  o_shift_cnt,
  output logic             o_oe_active
);

  localparam int              C_BLANKW     = 3;
  localparam logic [C_BLANKW-1:0] C_BLANK_LOAD = C_BLANKW'(SYNC_STAGES + 1);
  localparam logic [CNTW-1:0] C_CNT_MAX    = '1;
  localparam logic [CNTW-1:0] C_FRAME_LEN  = CNTW'(WIDTH);

  logic [SYNC_STAGES-1:0] shcp_sync_q, shcp_sync_d;
  logic [SYNC_STAGES-1:0] stcp_sync_q, stcp_sync_d;
  logic [SYNC_STAGES-1:0] ds_sync_q, ds_sync_d;
  // OE chain is one stage short: the inverting output flop is its last stage.
  logic [SYNC_STAGES-2:0] oe_sync_q, oe_sync_d;
  logic                   shcp_prev_q, shcp_prev_d;
  logic                   stcp_prev_q, stcp_prev_d;
  logic [C_BLANKW-1:0]    blank_q, blank_d;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   oe_active_q, oe_active_d;

  logic shcp_rise;
  logic stcp_rise;
  logic blanked;

  always_comb begin
    shcp_sync_d = {shcp_sync_q[SYNC_STAGES-2:0], i_shcp};
    stcp_sync_d = {stcp_sync_q[SYNC_STAGES-2:0], i_stcp};
    ds_sync_d   = {ds_sync_q[SYNC_STAGES-2:0], i_ds};
    oe_sync_d    = oe_sync_q << 1;
    oe_sync_d[0] = i_oe;
    oe_active_d  = ~oe_sync_q[SYNC_STAGES-2];

    shcp_prev_d = shcp_sync_q[SYNC_STAGES-1];
    stcp_prev_d = stcp_sync_q[SYNC_STAGES-1];

    blanked = (blank_q != '0);
    blank_d = blanked ? blank_q - C_BLANKW'(1) : blank_q;

    shcp_rise = ~blanked & shcp_sync_q[SYNC_STAGES-1] & ~shcp_prev_q;
    stcp_rise = ~blanked & stcp_sync_q[SYNC_STAGES-1] & ~stcp_prev_q;

    sr_d = shcp_rise ? {sr_q[WIDTH-2:0], ds_sync_q[SYNC_STAGES-1]} : sr_q;

    cnt_d = cnt_q;
    if (shcp_rise && (cnt_q != C_CNT_MAX)) cnt_d = cnt_q + CNTW'(1);
    // With tied clocks the latch sees the pre-shift word and pre-increment count.
    if (stcp_rise) cnt_d = shcp_rise ? CNTW'(1) : '0;

    data_d  = stcp_rise ? sr_q : data_q;
    valid_d = stcp_rise;
    err_d   = stcp_rise && (cnt_q != C_FRAME_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shcp_sync_q <= '0;
      stcp_sync_q <= '0;
      ds_sync_q   <= '0;
      oe_sync_q   <= '0;
      shcp_prev_q <= 1'b0;
      stcp_prev_q <= 1'b0;
      blank_q     <= C_BLANK_LOAD;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      oe_active_q <= 1'b0;
    end else begin
      shcp_sync_q <= shcp_sync_d;
      stcp_sync_q <= stcp_sync_d;
      ds_sync_q   <= ds_sync_d;
      oe_sync_q   <= oe_sync_d;
      shcp_prev_q <= shcp_prev_d;
      stcp_prev_q <= stcp_prev_d;
      blank_q     <= blank_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      oe_active_q <= oe_active_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_shift_cnt = cnt_q;
  assign o_oe_active = oe_active_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_74hc595.sv
// tb_rx_74hc595 -- scoreboard bench for rx_74hc595 (WIDTH=12, SYNC_STAGES=2).
// Rev 1.0
`default_nettype none

module tb_rx_74hc595;

  localparam int WIDTH = 12;
  localparam int SS    = 2;
  localparam int CNTW  = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_shcp = 1'b0;
  logic             i_stcp = 1'b0;
  logic             i_ds = 1'b0;
  logic             i_oe = 1'b1;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_err;
  logic [CNTW-1:0]  o_shift_cnt;
  logic             o_oe_active;

  rx_74hc595 #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_shcp      (i_shcp),
    .i_stcp      (i_stcp),
    .i_ds        (i_ds),
    .i_oe        (i_oe),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_err       (o_err),
    .o_shift_cnt (o_shift_cnt),
    .o_oe_active (o_oe_active)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0]   sb_q[$];   // {err, data}
  logic [WIDTH:0]   mon_exp;
  logic [WIDTH-1:0] m_sr;
  int               m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bit(input logic b);
    i_ds = b;
    tick(4);
    i_shcp = 1'b1;
    m_sr = {m_sr[WIDTH-2:0], b};
    if (m_cnt < 63) m_cnt++;
    tick(4);
    i_shcp = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch_frame();
    sb_q.push_back({m_cnt != WIDTH, m_sr});
    m_cnt = 0;
    i_stcp = 1'b1;
    tick(4);
    i_stcp = 1'b0;
    tick(4);
  endtask

  task automatic tied_edge(input logic b);
    i_ds = b;
    tick(4);
    sb_q.push_back({m_cnt != WIDTH, m_sr});
    m_sr  = {m_sr[WIDTH-2:0], b};
    m_cnt = 1;
    i_shcp = 1'b1;
    i_stcp = 1'b1;
    tick(4);
    check("tied_cnt", 32'(o_shift_cnt), 32'd1);
    i_shcp = 1'b0;
    i_stcp = 1'b0;
  endtask

  task automatic model_reset();
    m_sr  = '0;
    m_cnt = 0;
  endtask

  // Every latched frame is popped and compared when the DUT strobes it.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("frame_data", 32'(o_data), 32'(mon_exp[WIDTH-1:0]));
        check("frame_err", 32'(o_err), 32'(mon_exp[WIDTH]));
      end
    end else if (o_err === 1'b1) begin
      check("err_without_valid", 32'(o_err), 32'd0);
    end
  end

  logic [11:0] pat_a;
  logic [11:0] pat_b;

  initial begin
    model_reset();
    tick(3);
    rst = 1'b0;
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_cnt", 32'(o_shift_cnt), 32'd0);
    check("rst_oe", 32'(o_oe_active), 32'd0);
    tick(6);

    // Nominal frame
    send_word(32'hA5C, 12);
    check("nom_cnt", 32'(o_shift_cnt), 32'd12);
    latch_frame();
    check("nom_cnt_clr", 32'(o_shift_cnt), 32'd0);
    check("nom_data_hold", 32'(o_data), 32'hA5C);

    // Short and long frames
    send_word(32'h5A3, 11);
    check("short_cnt", 32'(o_shift_cnt), 32'd11);
    latch_frame();
    send_word(32'h1ABC, 13);
    check("long_cnt", 32'(o_shift_cnt), 32'd13);
    latch_frame();

    // Tied clocks, preceded by 12 plain shifts so one latch sees a full count
    send_word(32'h0F0, 12);
    pat_a = 12'h0F0;
    pat_b = 12'h3C3;
    for (int i = 11; i >= 0; i--) tied_edge(pat_a[i]);
    for (int i = 11; i >= 0; i--) tied_edge(pat_b[i]);
    tick(4);

    // Reset in the middle of a frame
    send_word(32'h2B, 6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_err", 32'(o_err), 32'd0);
    check("midrst_cnt", 32'(o_shift_cnt), 32'd0);
    check("midrst_oe", 32'(o_oe_active), 32'd0);
    tick(5);
    send_word(32'h123, 12);
    latch_frame();
    check("midrst_frame", 32'(o_data), 32'h123);

    // Pins already high at reset release must not register as edges
    i_shcp = 1'b1;
    i_stcp = 1'b1;
    i_ds   = 1'b1;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("blank_valid", 32'(o_valid), 32'd0);
      check("blank_cnt", 32'(o_shift_cnt), 32'd0);
    end
    i_shcp = 1'b0;
    i_stcp = 1'b0;
    i_ds   = 1'b0;
    tick(4);
    check("blank_cnt_after", 32'(o_shift_cnt), 32'd0);
    check("blank_data", 32'(o_data), 32'd0);
    latch_frame();

    // OE inversion and latency
    i_oe = 1'b0;
    tick(1);
    check("oe_lag0", 32'(o_oe_active), 32'd0);
    tick(1);
    check("oe_on", 32'(o_oe_active), 32'd1);
    i_oe = 1'b1;
    tick(1);
    check("oe_lag1", 32'(o_oe_active), 32'd1);
    tick(1);
    check("oe_off", 32'(o_oe_active), 32'd0);

    // STCP sampled at edge k gives o_valid at edge k+2
    sb_q.push_back({m_cnt != WIDTH, m_sr});
    m_cnt = 0;
    i_stcp = 1'b1;
    tick(1);
    check("lat_k", 32'(o_valid), 32'd0);
    tick(1);
    check("lat_k1", 32'(o_valid), 32'd0);
    tick(1);
    check("lat_k2", 32'(o_valid), 32'd1);
    tick(1);
    check("lat_k3", 32'(o_valid), 32'd0);
    i_stcp = 1'b0;
    tick(4);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
